stack_unit: RTL and testbench
=============================

// Module: stack_unit
// PURPOSE
//   Operand stack of the multicycle stack CPU; executes the push/pop/stack_src
//   commands issued by the control FSM each cycle. Presents top-of-stack
//   combinationally so A/B registers, data memory and the jz test sample it in
//   the same cycle as the pop. Reports full/empty and sticky overflow/underflow.
// PARAMETERS
//   WIDTH  8  data width of each entry (matches tos/ALU/MDR width)
//   DEPTH  8  number of entries; CW = $clog2(DEPTH+1) is the count width
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   push       in   1      push command from control FSM
//   pop        in   1      pop command from control FSM
//   stack_src  in   1      push data select: 0 = alu_in, 1 = mdr_in
//   alu_in     in   WIDTH  ALU result
//   mdr_in     in   WIDTH  memory data register value
//   clr_err    in   1      synchronous clear of overflow/underflow flags
//   tos        out  WIDTH  top entry; 0 when empty
//   nos        out  WIDTH  entry below top; 0 when count < 2
//   count      out  CW     number of valid entries, 0..DEPTH
//   empty      out  1      count == 0
//   full       out  1      count == DEPTH
//   overflow   out  1      sticky: push attempted while full
//   underflow  out  1      sticky: pop attempted while empty
// BEHAVIOUR
//   - Storage: DEPTH x WIDTH register array; count is the stack pointer
//     (next free slot). Top = mem[count-1].
//   - din = stack_src ? mdr_in : alu_in (combinational).
//   - Reset (async, any time incl. mid-command): count=0, overflow=0,
//     underflow=0 immediately; tos=nos=0, empty=1, full=0. Array contents are
//     not cleared and are never observable after reset (outputs gated by count).
//   - tos/nos/empty/full are combinational from count and array; zero latency.
//   - All updates on rising clk; command effect visible on outputs next cycle.
//   - Per-cycle command table:
//     none       : no change.
//     push only  : if !full: mem[count]<=din, count+1. if full: no write,
//                  count unchanged, overflow<=1.
//     pop only   : if !empty: count-1 (entry left in array). if empty:
//                  count unchanged, underflow<=1.
//     push & pop : if !empty: replace top, mem[count-1]<=din, count unchanged
//                  (read-modify-write; full does not block it). if empty:
//                  behaves as push only (count becomes 1), underflow<=1.
//   - Wrap-around: none; count saturates at 0 and DEPTH, pointer never wraps.
//   - clr_err: overflow<=0, underflow<=0 at the edge; if a new violation occurs
//     in the same cycle the flag is set (set wins over clear).
//   - Flags never affect command acceptance; CPU may keep running.
//   - No X on any output after reset when inputs are known.
// TESTING
//   1 Reset: assert reset mid-cycle with count=3 -> count=0, tos=0, empty=1,
//     flags 0 before next clk edge.
//   2 Push 5 (src=ALU), push 7 (src=MDR) -> tos=7, nos=5, count=2; pop ->
//     tos=5, nos=0, count=1.
//   3 Fill: DEPTH=8 pushes 1..8 -> full=1, tos=8; 9th push of 9 -> tos=8,
//     count=8, overflow=1; clr_err -> overflow=0.
//   4 Underflow: empty, pop -> count=0, tos=0, underflow=1; push&pop of 3 while
//     empty -> count=1, tos=3, underflow stays 1.
//   5 Replace: stack [4,6], push&pop with alu_in=10 -> tos=10, nos=4, count=2;
//     same on full stack -> count=8, no overflow.
//   6 Same-cycle clr_err + push while full -> overflow=1 after edge.

Source files
------------

// File: rtl/stack_unit.sv
// Operand stack for the multicycle stack CPU.
// Executes push / pop / replace-top commands from the control FSM each cycle.
// Top-of-stack and next-on-stack are combinational, so the rest of the datapath
// can sample them in the same cycle as the pop. The overflow and underflow flags
// are sticky until clr_err is asserted. When a new violation occurs in the same
// cycle as clr_err, the flag is set, because set wins over clear.
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             stack_src,
  input  logic [WIDTH-1:0] alu_in,
  input  logic [WIDTH-1:0] mdr_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] TWO_C   = CW'(2);

  // The array is never reset. Stale entries cannot be observed, because every
  // read is gated by count.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] din;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    nos_idx;
  logic             is_empty;
  logic             is_full;
  logic             has_two;

  assign din      = stack_src ? mdr_in : alu_in;
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);
  assign has_two  = (count_q >= TWO_C);
  assign top_idx  = AW'(count_q - ONE_C);
  assign nos_idx  = AW'(count_q - TWO_C);

  // Combinational read ports: zero-latency top and next-on-stack, forced to 0 when absent.
  always_comb begin
    tos = '0;
    nos = '0;
    if (!is_empty) begin
      tos = mem_q[top_idx];
    end
    if (has_two) begin
      nos = mem_q[nos_idx];
    end
  end

  // Command decode: next pointer, write strobe and sticky flag updates.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q & ~clr_err;
    unf_d   = unf_q & ~clr_err;
    wr_en   = 1'b0;
    wr_idx  = AW'(count_q);
    case ({push, pop})
      2'b10: begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_idx  = AW'(count_q);
          count_d = count_q + ONE_C;
        end
      end
      2'b01: begin
        if (is_empty) begin
          unf_d = 1'b1;
        end else begin
          count_d = count_q - ONE_C;
        end
      end
      2'b11: begin
        if (is_empty) begin
          // On an empty stack there is no top to replace, so the command acts
          // as a plain push and also flags the pop half as an underflow.
          wr_en   = 1'b1;
          wr_idx  = '0;
          count_d = ONE_C;
          unf_d   = 1'b1;
        end else begin
          // Replace top. The count does not move, so a full stack does not block it.
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  // Pointer and sticky flags. The async reset returns to the empty state immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= din;
    end
  end

  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit.
// The driver issues one command per cycle and pushes the state that a
// queue-based stack model predicts. The monitor pops one expectation one time
// unit after each clock edge and compares it against the DUT outputs.
module tb_stack_unit;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             push, pop, stack_src, clr_err;
  logic [WIDTH-1:0] alu_in, mdr_in;
  logic [WIDTH-1:0] tos, nos;
  logic [CW-1:0]    count;
  logic             empty, full, overflow, underflow;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    string tag;
    int    e_tos;
    int    e_nos;
    int    e_cnt;
    int    e_emp;
    int    e_ful;
    int    e_ovf;
    int    e_unf;
  } exp_t;

  exp_t sb[$];

  // Reference model: a plain queue of values, with the back of the queue as the top.
  int stk[$];
  bit m_ovf, m_unf;

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .stack_src(stack_src),
    .alu_in(alu_in), .mdr_in(mdr_in), .clr_err(clr_err),
    .tos(tos), .nos(nos), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
  endtask

  function automatic exp_t model_snapshot(input string tag);
    exp_t e;
    int n;
    n       = stk.size();
    e.tag   = tag;
    e.e_tos = (n > 0) ? stk[n-1] : 0;
    e.e_nos = (n > 1) ? stk[n-2] : 0;
    e.e_cnt = n;
    e.e_emp = (n == 0) ? 1 : 0;
    e.e_ful = (n == DEPTH) ? 1 : 0;
    e.e_ovf = m_ovf ? 1 : 0;
    e.e_unf = m_unf ? 1 : 0;
    return e;
  endfunction

  // One command cycle: drive just after the edge, then predict the state after the next edge.
  task automatic cycle(input bit pu, input bit po, input bit src, input int val,
                       input bit clr, input string tag);
    bit vo, vu;
    @(posedge clk);
    #2;
    push      = pu;
    pop       = po;
    stack_src = src;
    clr_err   = clr;
    if (src) begin
      mdr_in = WIDTH'(val);
      alu_in = WIDTH'($urandom);
    end else begin
      alu_in = WIDTH'(val);
      mdr_in = WIDTH'($urandom);
    end
    vo = 1'b0;
    vu = 1'b0;
    if (pu && po) begin
      if (stk.size() > 0) stk[stk.size()-1] = val & 8'hFF;
      else begin
        stk.push_back(val & 8'hFF);
        vu = 1'b1;
      end
    end else if (pu) begin
      if (stk.size() < DEPTH) stk.push_back(val & 8'hFF);
      else vo = 1'b1;
    end else if (po) begin
      if (stk.size() > 0) void'(stk.pop_back());
      else vu = 1'b1;
    end
    m_ovf = vo | (m_ovf & ~clr);
    m_unf = vu | (m_unf & ~clr);
    sb.push_back(model_snapshot(tag));
  endtask

  // Asserts reset in the middle of an idle cycle and checks that the outputs clear before the next edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    push = 0; pop = 0; clr_err = 0;
    #3;
    reset = 1'b1;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_tos", int'(tos), 0);
    chk("rst_nos", int'(nos), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_unf", int'(underflow), 0);
    #1;
    reset = 1'b0;
    stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Monitor: compares the DUT against the oldest pending expectation, just after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, ".tos"},   int'(tos),       e.e_tos);
        chk({e.tag, ".nos"},   int'(nos),       e.e_nos);
        chk({e.tag, ".count"}, int'(count),     e.e_cnt);
        chk({e.tag, ".empty"}, int'(empty),     e.e_emp);
        chk({e.tag, ".full"},  int'(full),      e.e_ful);
        chk({e.tag, ".ovf"},   int'(overflow),  e.e_ovf);
        chk({e.tag, ".unf"},   int'(underflow), e.e_unf);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d expected 0", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    push = 0; pop = 0; stack_src = 0; clr_err = 0; alu_in = '0; mdr_in = '0;
    m_ovf = 0; m_unf = 0;
    #12;
    chk("por_count", int'(count), 0);
    chk("por_empty", int'(empty), 1);
    chk("por_tos", int'(tos), 0);
    reset = 1'b0;

    // Set the underflow flag and put three entries on the stack, then reset mid-cycle.
    cycle(0, 1, 0, 0, 0, "t1_pop_empty");
    cycle(1, 0, 0, 11, 0, "t1_push");
    cycle(1, 0, 1, 22, 0, "t1_push");
    cycle(1, 0, 0, 33, 0, "t1_push");
    do_reset();

    // Basic push from each source, then a pop.
    cycle(1, 0, 0, 5, 0, "t2_push_alu");
    cycle(1, 0, 1, 7, 0, "t2_push_mdr");
    cycle(0, 1, 0, 0, 0, "t2_pop");
    do_reset();

    // Fill the stack, push once more to overflow, then clear the flag.
    for (int i = 1; i <= DEPTH; i++) cycle(1, 0, 1'($urandom_range(0, 1)), i, 0, "t3_fill");
    cycle(1, 0, 0, 9, 0, "t3_push_full");
    cycle(0, 0, 0, 0, 1, "t3_clr");
    do_reset();

    // Underflow from a pop on empty, then push&pop on empty.
    cycle(0, 1, 0, 0, 0, "t4_pop_empty");
    cycle(1, 1, 0, 3, 0, "t4_pushpop_empty");
    do_reset();

    // Replace top on a partial stack and on a full stack.
    cycle(1, 0, 0, 4, 0, "t5_push");
    cycle(1, 0, 0, 6, 0, "t5_push");
    cycle(1, 1, 0, 10, 0, "t5_replace");
    for (int i = 0; i < DEPTH - 2; i++) cycle(1, 0, 1, 40 + i, 0, "t5_fill");
    cycle(1, 1, 1, 99, 0, "t5_replace_full");

    // A new overflow in the same cycle as clr_err: the set wins.
    cycle(1, 0, 0, 77, 1, "t6_clr_and_ovf");
    cycle(0, 0, 0, 0, 0, "t6_idle");

    // Random traffic. Each block picks a push/pop bias so the stack reaches both full and empty.
    for (int blk = 0; blk < 12; blk++) begin
      int bias;
      bias = int'($urandom_range(0, 2));
      for (int c = 0; c < 50; c++) begin
        bit pu, po;
        if ($urandom_range(0, 99) == 0) do_reset();
        case (bias)
          0:       begin pu = ($urandom_range(0, 99) < 70); po = ($urandom_range(0, 99) < 25); end
          1:       begin pu = ($urandom_range(0, 99) < 25); po = ($urandom_range(0, 99) < 70); end
          default: begin pu = ($urandom_range(0, 99) < 50); po = ($urandom_range(0, 99) < 50); end
        endcase
        cycle(pu, po, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
              ($urandom_range(0, 9) == 0), "rnd");
      end
    end

    repeat (3) @(posedge clk);
    #3;
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
